alu_uart_ctrl: RTL and testbench
================================

// Module: alu_uart_ctrl
// PURPOSE
//  Command sequencer between a UART RX/TX pair and the combinational ALU: collects three
//  bytes (A, B, OP), holds them on the ALU inputs, then returns the result byte and
//  optionally a flags byte. Replaces switch/button loading when the ALU is driven from a
//  host PC. Pure control: owns the operand/opcode registers and the TX handshake, no arithmetic.
// PARAMETERS
//  NB_DATA     8      UART byte width; also ALU operand/result width
//  NB_OP       6      ALU opcode width, taken from rx byte [NB_OP-1:0]
//  SEND_FLAGS  1      1: send flags byte {zeros,carry,zero} after result; 0: result only
//  TIMEOUT_CYC 50000  max clk cycles between bytes of one command; 0 disables timeout
// PORTS
//  clk           in   1        system clock, all logic on rising edge
//  rst_n         in   1        synchronous reset, ACTIVE-HIGH (1 = reset)
//  i_rx_data     in   NB_DATA  received byte, valid when i_rx_done=1
//  i_rx_done     in   1        1-cycle strobe: new byte on i_rx_data
//  i_tx_busy     in   1        TX serializer busy
//  i_tx_done     in   1        1-cycle strobe: TX finished current byte
//  o_tx_start    out  1        1-cycle strobe: load o_tx_data into TX
//  o_tx_data     out  NB_DATA  byte to transmit, stable from o_tx_start until i_tx_done
//  o_alu_a       out  NB_DATA  registered operand A to ALU
//  o_alu_b       out  NB_DATA  registered operand B to ALU
//  o_alu_op      out  NB_OP    registered opcode to ALU
//  i_alu_result  in   NB_DATA  ALU result (combinational from o_alu_*)
//  i_alu_carry   in   1        ALU carry
//  i_alu_zero    in   1        ALU zero
//  o_busy        out  1        1 in any state other than WAIT_A
//  o_err         out  1        1-cycle pulse: invalid opcode or inter-byte timeout
//  o_overrun     out  1        1-cycle pulse: byte received in EXEC/TX states (byte dropped)
// BEHAVIOUR
//  Reset: state WAIT_A; all o_* = 0; result/flags capture regs and timeout counter = 0.
//  FSM: WAIT_A -rx-> WAIT_B -rx-> WAIT_OP -rx(valid op)-> EXEC -> TX_RES -> WAIT_RES
//       -done-> (SEND_FLAGS ? TX_FLG -> WAIT_FLG -done-> : ) WAIT_A.
//  WAIT_A/WAIT_B: i_rx_done loads o_alu_a / o_alu_b in the same edge, advances.
//  WAIT_OP: i_rx_done with opcode in {ADD,SUB,AND,OR,XOR,NOR,SRA,SRL} loads o_alu_op ->
//   EXEC; any other opcode: o_err pulse next cycle, o_alu_op unchanged, -> WAIT_A.
//  EXEC: one cycle for ALU settle; captures i_alu_result, {carry,zero} into regs.
//  TX_RES/TX_FLG: when i_tx_busy=0 assert o_tx_start for exactly 1 cycle with o_tx_data =
//   captured byte, go to WAIT_*; if busy, hold state, no strobe.
//  Latency: op byte strobe at cycle N -> EXEC N+1 -> o_tx_start at N+2 (TX idle).
//  o_alu_a/b/op hold last loaded values after command completes (ALU output stays visible).
//  Timeout: counter clears on every accepted byte, counts in WAIT_B/WAIT_OP; reaching
//   TIMEOUT_CYC -> o_err pulse, -> WAIT_A, operand regs keep partial values.
//  i_rx_done in EXEC/TX_*/WAIT_RES/WAIT_FLG: byte dropped, o_overrun pulse, state unaffected.
//  i_tx_done outside WAIT_RES/WAIT_FLG: ignored.
//  rst_n mid-command: overrides everything next edge; no o_tx_start issued after reset.
//  Flags byte = {(NB_DATA-2)'b0, carry, zero}.
// STRUCTURE
//  Shared package alu_pkg: opcode localparams (ADD 6'b100000, SUB 6'b100010, AND 6'b100100,
//   OR 6'b100101, XOR 6'b100110, NOR 6'b100111, SRA 6'b000011, SRL 6'b000010), state encoding,
//   and opcode-valid function; ALU uses the same package.
//  One sub-module: timeout_cnt (clear, enable, terminal-count pulse; width $clog2(TIMEOUT_CYC+1)).
//  FSM, operand regs, capture regs and TX strobe in this module.
// TESTING
//  1 rx 0x05,0x03,0x20 (ADD), TX idle -> o_tx_start N+2, o_tx_data 0x08, then flags 0x00.
//  2 rx 0x03,0x05,0x22 (SUB) -> result 0xFE, flags 0x00; rx 0x04,0x04,0x22 -> 0x00, flags 0x01.
//  3 rx 0xFF,0x01,0x20 -> result 0x00, flags 0x03 (carry+zero); SEND_FLAGS=0 -> one byte only.
//  4 rx 0x01,0x02,0x3F -> o_err 1 cycle, no o_tx_start, o_busy=0, o_alu_op unchanged.
//  5 TIMEOUT_CYC=100: rx 0x01 then idle 100 cycles -> o_err, WAIT_A; next 3 bytes run OK.
//  6 i_tx_busy=1 at TX_RES -> no strobe until busy drops; rx during WAIT_RES -> o_overrun;
//    rst_n=1 in WAIT_RES -> all outputs 0 next cycle, no further TX.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, sequencer state encoding and opcode check
package alu_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_W-1:0] OP_AND = 6'b100100;
  localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
  localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
  localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

  typedef enum logic [2:0] {
    ST_WAIT_A,
    ST_WAIT_B,
    ST_WAIT_OP,
    ST_EXEC,
    ST_TX_RES,
    ST_WAIT_RES,
    ST_TX_FLG,
    ST_WAIT_FLG
  } state_t;

  function automatic logic op_valid(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL: op_valid = 1'b1;
      default: op_valid = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_uart_ctrl_if.sv
// rtl/alu_uart_ctrl_if.sv - UART/ALU side signals of the command sequencer
interface alu_uart_ctrl_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_done;
  logic               i_tx_busy;
  logic               i_tx_done;
  logic               o_tx_start;
  logic [NB_DATA-1:0] o_tx_data;
  logic [NB_DATA-1:0] o_alu_a;
  logic [NB_DATA-1:0] o_alu_b;
  logic [NB_OP-1:0]   o_alu_op;
  logic [NB_DATA-1:0] i_alu_result;
  logic               i_alu_carry;
  logic               i_alu_zero;
  logic               o_busy;
  logic               o_err;
  logic               o_overrun;

  modport master (
    input  i_rx_data, i_rx_done, i_tx_busy, i_tx_done, i_alu_result, i_alu_carry, i_alu_zero,
    output o_tx_start, o_tx_data, o_alu_a, o_alu_b, o_alu_op, o_busy, o_err, o_overrun
  );

  modport slave (
    output i_rx_data, i_rx_done, i_tx_busy, i_tx_done, i_alu_result, i_alu_carry, i_alu_zero,
    input  o_tx_start, o_tx_data, o_alu_a, o_alu_b, o_alu_op, o_busy, o_err, o_overrun
  );
endinterface

// File: rtl/alu_uart_ctrl_timeout_cnt.sv
// rtl/alu_uart_ctrl_timeout_cnt.sv - inter-byte timeout counter, saturates at LIMIT
// LIMIT of 0 disables the terminal count entirely.
module timeout_cnt #(
  parameter int unsigned LIMIT = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);
  localparam int unsigned W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst_n || clear) begin
      count <= '0;
    end else if (enable && !tc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (LIMIT != 0) && (count == W'(LIMIT));
endmodule

// File: rtl/alu_uart_ctrl.sv
// rtl/alu_uart_ctrl.sv - UART command sequencer feeding the combinational ALU
// Collects A, B, OP bytes, holds them on the ALU, returns result and optional flags byte.
module alu_uart_ctrl
  import alu_pkg::*;
#(
  parameter int NB_DATA     = 8,
  parameter int NB_OP       = 6,
  parameter int SEND_FLAGS  = 1,
  parameter int TIMEOUT_CYC = 50000
) (
  input logic             clk,
  input logic             rst_n,
  alu_uart_ctrl_if.master bus
);
  state_t             state, state_nx;
  logic               load_a, load_b, load_op, capture, err_set, ovr_set, tx_start;
  logic               tmo, rx_state, cnt_en;
  logic [NB_DATA-1:0] res_q;
  logic [1:0]         flg_q;

  assign rx_state = state inside {ST_WAIT_A, ST_WAIT_B, ST_WAIT_OP};
  assign cnt_en   = state inside {ST_WAIT_B, ST_WAIT_OP};

  timeout_cnt #(.LIMIT(TIMEOUT_CYC)) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (bus.i_rx_done || !cnt_en),
    .enable (cnt_en),
    .tc     (tmo)
  );

  always_ff @(posedge clk) begin
    if (rst_n) state <= ST_WAIT_A;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load_a   = 1'b0;
    load_b   = 1'b0;
    load_op  = 1'b0;
    capture  = 1'b0;
    err_set  = 1'b0;
    ovr_set  = 1'b0;
    tx_start = 1'b0;
    case (state)
      ST_WAIT_A: if (bus.i_rx_done) begin
        load_a   = 1'b1;
        state_nx = ST_WAIT_B;
      end
      ST_WAIT_B: if (bus.i_rx_done) begin
        load_b   = 1'b1;
        state_nx = ST_WAIT_OP;
      end else if (tmo) begin
        err_set  = 1'b1;
        state_nx = ST_WAIT_A;
      end
      ST_WAIT_OP: if (bus.i_rx_done) begin
        if (op_valid(OP_W'(bus.i_rx_data[NB_OP-1:0]))) begin
          load_op  = 1'b1;
          state_nx = ST_EXEC;
        end else begin
          err_set  = 1'b1;
          state_nx = ST_WAIT_A;
        end
      end else if (tmo) begin
        err_set  = 1'b1;
        state_nx = ST_WAIT_A;
      end
      ST_EXEC: begin
        capture  = 1'b1;
        state_nx = ST_TX_RES;
      end
      // Reset asserted this cycle must not leak a strobe to the serializer.
      ST_TX_RES: if (!bus.i_tx_busy && !rst_n) begin
        tx_start = 1'b1;
        state_nx = ST_WAIT_RES;
      end
      ST_WAIT_RES: if (bus.i_tx_done) state_nx = (SEND_FLAGS != 0) ? ST_TX_FLG : ST_WAIT_A;
      ST_TX_FLG: if (!bus.i_tx_busy && !rst_n) begin
        tx_start = 1'b1;
        state_nx = ST_WAIT_FLG;
      end
      ST_WAIT_FLG: if (bus.i_tx_done) state_nx = ST_WAIT_A;
      default: state_nx = ST_WAIT_A;
    endcase
    if (bus.i_rx_done && !rx_state) ovr_set = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      bus.o_alu_a   <= '0;
      bus.o_alu_b   <= '0;
      bus.o_alu_op  <= '0;
      res_q         <= '0;
      flg_q         <= '0;
      bus.o_err     <= 1'b0;
      bus.o_overrun <= 1'b0;
    end else begin
      if (load_a)  bus.o_alu_a  <= bus.i_rx_data;
      if (load_b)  bus.o_alu_b  <= bus.i_rx_data;
      if (load_op) bus.o_alu_op <= bus.i_rx_data[NB_OP-1:0];
      if (capture) begin
        res_q <= bus.i_alu_result;
        flg_q <= {bus.i_alu_carry, bus.i_alu_zero};
      end
      bus.o_err     <= err_set;
      bus.o_overrun <= ovr_set;
    end
  end

  assign bus.o_tx_start = tx_start;
  assign bus.o_tx_data  = (state inside {ST_TX_FLG, ST_WAIT_FLG})
                          ? {{(NB_DATA-2){1'b0}}, flg_q} : res_q;
  assign bus.o_busy     = (state != ST_WAIT_A);
endmodule

// File: tb/tb_alu_uart_ctrl.sv
// tb/tb_alu_uart_ctrl.sv - scoreboard bench for the ALU UART command sequencer
// dut1 sends result+flags, dut0 result only; both share the rx stream.
module tb_alu_uart_ctrl;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       force_busy = 1'b0;

  alu_uart_ctrl_if #(.NB_DATA(8), .NB_OP(6)) bus1 ();
  alu_uart_ctrl_if #(.NB_DATA(8), .NB_OP(6)) bus0 ();

  alu_uart_ctrl #(.NB_DATA(8), .NB_OP(6), .SEND_FLAGS(1), .TIMEOUT_CYC(100)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  alu_uart_ctrl #(.NB_DATA(8), .NB_OP(6), .SEND_FLAGS(0), .TIMEOUT_CYC(100)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));

  function automatic logic [9:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    logic [8:0] s;
    logic [7:0] r;
    logic       c;
    c = 1'b0;
    s = 9'h000;
    case (op)
      OP_ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
      OP_SUB: r = a - b;
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOR: r = ~(a | b);
      OP_SRA: r = 8'($signed(a) >>> b);
      OP_SRL: r = a >> b;
      default: r = 8'h00;
    endcase
    return {c, (r == 8'h00), r};
  endfunction

  logic [9:0] alu1, alu0;
  assign alu1 = alu_f(bus1.o_alu_a, bus1.o_alu_b, bus1.o_alu_op);
  assign alu0 = alu_f(bus0.o_alu_a, bus0.o_alu_b, bus0.o_alu_op);
  assign bus1.i_alu_result = alu1[7:0];
  assign bus1.i_alu_zero   = alu1[8];
  assign bus1.i_alu_carry  = alu1[9];
  assign bus0.i_alu_result = alu0[7:0];
  assign bus0.i_alu_zero   = alu0[8];
  assign bus0.i_alu_carry  = alu0[9];
  assign bus1.i_rx_data = rx_data;
  assign bus1.i_rx_done = rx_done;
  assign bus0.i_rx_data = rx_data;
  assign bus0.i_rx_done = rx_done;

  // TX serializer stand-ins: busy for six cycles after each start, then a done strobe.
  logic tx_busy1 = 1'b0, tx_done1 = 1'b0, tx_busy0 = 1'b0, tx_done0 = 1'b0;
  int   tx_cnt1 = 0, tx_cnt0 = 0;
  always @(posedge clk) begin
    tx_done1 <= 1'b0;
    if (bus1.o_tx_start) begin
      tx_busy1 <= 1'b1; tx_cnt1 <= 6;
    end else if (tx_cnt1 > 0) begin
      tx_cnt1 <= tx_cnt1 - 1;
      if (tx_cnt1 == 1) begin tx_busy1 <= 1'b0; tx_done1 <= 1'b1; end
    end
  end
  always @(posedge clk) begin
    tx_done0 <= 1'b0;
    if (bus0.o_tx_start) begin
      tx_busy0 <= 1'b1; tx_cnt0 <= 6;
    end else if (tx_cnt0 > 0) begin
      tx_cnt0 <= tx_cnt0 - 1;
      if (tx_cnt0 == 1) begin tx_busy0 <= 1'b0; tx_done0 <= 1'b1; end
    end
  end
  assign bus1.i_tx_busy = tx_busy1 | force_busy;
  assign bus1.i_tx_done = tx_done1;
  assign bus0.i_tx_busy = tx_busy0 | force_busy;
  assign bus0.i_tx_done = tx_done0;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;
  exp_t q1[$];
  exp_t q0[$];
  int   err_pend[2];
  int   ovr_pend[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic mon(input int id, input logic start, input logic [7:0] data,
                     input logic err, input logic ovr);
    exp_t e;
    bit   have;
    if (start) begin
      have = (id == 1) ? (q1.size() != 0) : (q0.size() != 0);
      checks++;
      if (!have) begin
        errors++;
        $display("FAIL tx%0d_unexpected got=%02h@%0d want=none", id, data, cyc);
      end else begin
        if (id == 1) e = q1.pop_front();
        else         e = q0.pop_front();
        if (data !== e.data || (e.cyc >= 0 && cyc != e.cyc)) begin
          errors++;
          $display("FAIL tx%0d_byte got=%02h@%0d want=%02h@%0d", id, data, cyc, e.data, e.cyc);
        end
      end
    end
    if (err) begin
      checks++;
      if (err_pend[id] == 0) begin
        errors++;
        $display("FAIL err%0d_unexpected got=1 want=0 at %0d", id, cyc);
      end else err_pend[id]--;
    end
    if (ovr) begin
      checks++;
      if (ovr_pend[id] == 0) begin
        errors++;
        $display("FAIL ovr%0d_unexpected got=1 want=0 at %0d", id, cyc);
      end else ovr_pend[id]--;
    end
  endtask

  always @(negedge clk) begin
    mon(1, bus1.o_tx_start, bus1.o_tx_data, bus1.o_err, bus1.o_overrun);
    mon(0, bus0.o_tx_start, bus0.o_tx_data, bus0.o_err, bus0.o_overrun);
  end

  task automatic send_byte(input logic [7:0] b, output int n);
    @(posedge clk); #1;
    rx_data = b; rx_done = 1'b1; n = cyc;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while ((bus1.o_busy || bus0.o_busy) && k < 300);
    chk(name, 32'(bus1.o_busy | bus0.o_busy), 32'd0);
  endtask

  task automatic push(input logic [7:0] d, input int c, input bit both);
    exp_t e;
    e.data = d; e.cyc = c;
    q1.push_back(e);
    if (both) q0.push_back(e);
  endtask

  task automatic send_cmd(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] op, input logic [7:0] res, input logic [7:0] flg);
    int n;
    send_byte(a, n);
    send_byte(b, n);
    send_byte(op, n);
    push(res, n + 2, 1'b1);
    push(flg, -1, 1'b0);
    wait_idle(name);
  endtask

  task automatic chk_zero(input string name);
    chk(name, 32'({bus1.o_tx_start, bus1.o_tx_data, bus1.o_alu_a, bus1.o_alu_b, bus1.o_alu_op,
                   bus1.o_busy, bus1.o_err, bus1.o_overrun}), 32'd0);
    chk(name, 32'({bus0.o_tx_start, bus0.o_tx_data, bus0.o_alu_a, bus0.o_alu_b, bus0.o_alu_op,
                   bus0.o_busy, bus0.o_err, bus0.o_overrun}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, c;
    err_pend[0] = 0; err_pend[1] = 0; ovr_pend[0] = 0; ovr_pend[1] = 0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_zero("reset_state");

    send_cmd("add_5_3",   8'h05, 8'h03, 8'h20, 8'h08, 8'h00);
    send_cmd("sub_3_5",   8'h03, 8'h05, 8'h22, 8'hFE, 8'h00);
    send_cmd("sub_4_4",   8'h04, 8'h04, 8'h22, 8'h00, 8'h01);
    send_cmd("add_ff_1",  8'hFF, 8'h01, 8'h20, 8'h00, 8'h03);
    send_cmd("and_f0_3c", 8'hF0, 8'h3C, 8'h24, 8'h30, 8'h00);
    send_cmd("sra_81_1",  8'h81, 8'h01, 8'h03, 8'hC0, 8'h00);

    // invalid opcode
    err_pend[1]++; err_pend[0]++;
    send_byte(8'h01, n); send_byte(8'h02, n); send_byte(8'h3F, n);
    wait_idle("badop_idle");
    chk("badop_op1", 32'(bus1.o_alu_op), 32'h03);
    chk("badop_op0", 32'(bus0.o_alu_op), 32'h03);
    chk("badop_a1", 32'(bus1.o_alu_a), 32'h01);

    // inter-byte timeout
    err_pend[1]++; err_pend[0]++;
    send_byte(8'h01, n);
    k = 0;
    do begin @(negedge clk); k++; end while (bus1.o_busy && k < 200);
    c = cyc;
    chk("tmo_window", 32'((c >= n + 100) && (c <= n + 103)), 32'd1);
    chk("tmo_keep_a", 32'(bus1.o_alu_a), 32'h01);
    chk("tmo_keep_b", 32'(bus1.o_alu_b), 32'h02);
    wait_idle("tmo_idle");
    send_cmd("xor_after_tmo", 8'h07, 8'h03, 8'h26, 8'h04, 8'h00);

    // TX busy hold, overrun in WAIT_RES, reset mid-command
    force_busy = 1'b1;
    send_byte(8'h09, n); send_byte(8'h02, n); send_byte(8'h22, n);
    push(8'h07, -1, 1'b1);
    repeat (6) begin
      @(negedge clk);
      chk("busy_hold", 32'(bus1.o_tx_start | bus0.o_tx_start), 32'd0);
    end
    chk("busy_hold_state", 32'(bus1.o_busy & bus0.o_busy), 32'd1);
    @(posedge clk); #1 force_busy = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus1.o_tx_start && k < 20);
    chk("tx_after_busy", 32'(bus1.o_tx_start), 32'd1);
    ovr_pend[1]++; ovr_pend[0]++;
    send_byte(8'h55, n);
    @(negedge clk);
    chk("ovr_state_kept", 32'(bus1.o_busy & bus0.o_busy), 32'd1);
    chk("ovr_a_kept", 32'(bus1.o_alu_a), 32'h09);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk_zero("mid_reset");
    repeat (20) @(negedge clk);
    send_cmd("add_after_reset", 8'h05, 8'h03, 8'h20, 8'h08, 8'h00);

    repeat (3) @(negedge clk);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("err_seen", 32'(err_pend[1] + err_pend[0]), 32'd0);
    chk("ovr_seen", 32'(ovr_pend[1] + ovr_pend[0]), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
